// File: rtl/mel_pkg.sv
// Shared constants, FSM state type and frame-slicing helper for the
// log-mel serializer.
package mel_pkg;

  localparam int unsigned N_BANDS    = 64;
  localparam int unsigned LOG_INT_BW = 6;
  localparam int unsigned GROUP_BW   = 7;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SERIAL = 1'b1
  } ser_state_t;

  // Bit offset of band k inside the packed frame (band 0 sits in the MSBs).
  function automatic int unsigned band_offset(input int unsigned bw,
                                              input logic [LOG_INT_BW-1:0] k);
    return bw * ((N_BANDS - 1) - 32'(k));
  endfunction

endpackage

// File: rtl/mel_log_serializer_log2.sv
// Combinational log2 approximation: leading-one position as the integer
// part, the bits directly below it (left-aligned) as the fraction.
// Non-positive inputs map to zero.
module log2_approx
  import mel_pkg::*;
#(
  parameter int unsigned I_BW    = 56,
  parameter int unsigned FRAC_BW = 8,
  parameter int unsigned LOG_BW  = LOG_INT_BW + FRAC_BW
) (
  input  logic signed [I_BW-1:0]   x,
  output logic        [LOG_BW-1:0] y
);

  logic [LOG_INT_BW-1:0] lead;
  logic [FRAC_BW-1:0]    frac;
  logic                  pos;

  // Priority leading-one detector: the highest set magnitude bit wins.
  always_comb begin
    lead = '0;
    for (int unsigned i = 0; i < I_BW - 1; i++) begin
      if (x[i]) lead = LOG_INT_BW'(i);
    end
  end

  // Normalising shift: appending FRAC_BW zeros and shifting right by the
  // leading-one position leaves the bits below it in the low FRAC_BW bits,
  // zero-padded when fewer than FRAC_BW bits exist.
  always_comb begin
    pos  = !x[I_BW-1] && (|x[I_BW-2:0]);
    frac = FRAC_BW'({x[I_BW-2:0], {FRAC_BW{1'b0}}} >> lead);
    y    = pos ? {lead, frac} : '0;
  end

endmodule

// File: rtl/mel_log_serializer.sv
// Captures a 64-band mel frame and streams one log2 band per cycle under a
// valid/ready handshake. Optional double buffering of an incoming frame while
// serializing is enabled by defining MEL_LOG_DBUF_EN.
module mel_log_serializer
  import mel_pkg::*;
#(
  parameter int unsigned I_BW    = 56,
  parameter int unsigned FRAC_BW = 8,
  parameter int unsigned LOG_BW  = LOG_INT_BW + FRAC_BW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [I_BW*N_BANDS-1:0]   data_i,
  input  logic                      di_en,
  input  logic [GROUP_BW-1:0]       in_group_num,
  input  logic                      ready_i,
  output logic [LOG_BW-1:0]         data_o,
  output logic                      do_en,
  output logic [LOG_INT_BW-1:0]     do_band,
  output logic                      do_last,
  output logic [GROUP_BW-1:0]       out_group_num,
  output logic                      busy,
  output logic                      ovf
);

  ser_state_t               state, state_nxt;
  logic [I_BW*N_BANDS-1:0]  frame_buf;
  logic [GROUP_BW-1:0]      frame_grp;
  logic [LOG_INT_BW-1:0]    band_k;
  logic signed [I_BW-1:0]   band_x;
  logic [LOG_BW-1:0]        band_log;
  logic                     ld, ld_last;
  logic                     take_direct, drop, promote;

  assign ld      = (state == ST_SERIAL) && (!do_en || ready_i);
  assign ld_last = ld && (band_k == LOG_INT_BW'(N_BANDS - 1));
  assign busy    = (state == ST_SERIAL);
  assign band_x  = $signed(I_BW'(frame_buf >> band_offset(I_BW, band_k)));

`ifdef MEL_LOG_DBUF_EN
  logic [I_BW*N_BANDS-1:0]  pend_buf;
  logic [GROUP_BW-1:0]      pend_grp;
  logic                     pend_v;
  logic                     take_pend;

  // A frame arriving as band 63 loads with the pending slot empty would be
  // promoted in the same cycle, so it is written straight into frame_buf.
  assign take_direct = di_en && ((state == ST_IDLE) || (ld_last && !pend_v));
  assign take_pend   = di_en && !take_direct && !pend_v;
  assign drop        = di_en && !take_direct && !take_pend;
  assign promote     = ld_last && pend_v;

  // Pending slot: filled during SERIAL, emptied when promoted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_buf <= '0;
      pend_grp <= '0;
      pend_v   <= 1'b0;
    end else if (take_pend) begin
      pend_buf <= data_i;
      pend_grp <= in_group_num;
      pend_v   <= 1'b1;
    end else if (promote) begin
      pend_v   <= 1'b0;
    end
  end
`else
  assign take_direct = di_en && (state == ST_IDLE);
  assign drop        = di_en && !take_direct;
  assign promote     = 1'b0;
`endif

  log2_approx #(
    .I_BW    (I_BW),
    .FRAC_BW (FRAC_BW),
    .LOG_BW  (LOG_BW)
  ) u_log2 (
    .x (band_x),
    .y (band_log)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next state: stay in SERIAL across frames when a follow-on frame is ready.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (take_direct) state_nxt = ST_SERIAL;
      ST_SERIAL: if (ld_last && !promote && !take_direct) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Frame buffer, band counter, output register and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_buf     <= '0;
      frame_grp     <= '0;
      band_k        <= '0;
      data_o        <= '0;
      do_en         <= 1'b0;
      do_band       <= '0;
      do_last       <= 1'b0;
      out_group_num <= '0;
      ovf           <= 1'b0;
    end else begin
      if (take_direct) begin
        frame_buf <= data_i;
        frame_grp <= in_group_num;
        band_k    <= '0;
`ifdef MEL_LOG_DBUF_EN
      end else if (promote) begin
        frame_buf <= pend_buf;
        frame_grp <= pend_grp;
        band_k    <= '0;
`endif
      end else if (ld) begin
        band_k    <= band_k + 1'b1;
      end

      if (ld) begin
        data_o        <= band_log;
        do_band       <= band_k;
        do_last       <= (band_k == LOG_INT_BW'(N_BANDS - 1));
        out_group_num <= frame_grp;
        do_en         <= 1'b1;
      end else if (ready_i) begin
        do_en         <= 1'b0;
      end

      if (drop) ovf <= 1'b1;
    end
  end

endmodule
